// File: rtl/mem_arbiter.sv
// Two-master arbiter that shares one single-port synchronous SRAM between fetch and data.
// Build with ARB_ROUND_ROBIN_EN defined for round-robin ties; by default data wins with a fetch starvation guard.
`timescale 1ns/1ps
module mem_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,

    input  logic        dm_req,
    input  logic [3:0]  dm_wen,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_gnt,
    output logic        dm_rvalid,
    output logic [31:0] dm_rdata,

    output logic        ram_en,
    output logic [3:0]  ram_wen,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RET_IF = 2'd1,
        RET_DM = 2'd2
    } ret_state_t;

    ret_state_t state_reg;
    ret_state_t state_next;

    logic fetch_wins;
    logic if_gnt_int;
    logic dm_gnt_int;
    logic dm_read;

`ifdef ARB_ROUND_ROBIN_EN
    // Remembers whether fetch took the most recent grant; a tie goes to the other side.
    logic last_fetch_reg;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_fetch_reg <= 1'b0;
        end else if (if_gnt_int) begin
            last_fetch_reg <= 1'b1;
        end else if (dm_gnt_int) begin
            last_fetch_reg <= 1'b0;
        end
    end

    assign fetch_wins = !last_fetch_reg;
`else
    localparam logic [3:0] STARVE_LIMIT = 4'(STARVE_MAX);

    logic [3:0] starve_cnt_reg;

    // Counts consecutive fetch losses; once it reaches the limit fetch wins the next tie.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            starve_cnt_reg <= 4'd0;
        end else if (if_gnt_int) begin
            starve_cnt_reg <= 4'd0;
        end else if (if_req && (starve_cnt_reg < STARVE_LIMIT)) begin
            starve_cnt_reg <= starve_cnt_reg + 4'd1;
        end
    end

    assign fetch_wins = (starve_cnt_reg == STARVE_LIMIT);
`endif

    // Grants are combinational and suppressed while reset is held.
    always_comb begin
        if_gnt_int = 1'b0;
        dm_gnt_int = 1'b0;
        if (resetn) begin
            if (if_req && dm_req) begin
                if_gnt_int = fetch_wins;
                dm_gnt_int = !fetch_wins;
            end else begin
                if_gnt_int = if_req;
                dm_gnt_int = dm_req;
            end
        end
    end

    assign if_gnt  = if_gnt_int;
    assign dm_gnt  = dm_gnt_int;
    assign dm_read = dm_gnt_int && (dm_wen == 4'b0000);

    always_comb begin
        ram_en    = 1'b0;
        ram_wen   = 4'b0000;
        ram_addr  = 32'd0;
        ram_wdata = 32'd0;
        if (dm_gnt_int) begin
            ram_en    = 1'b1;
            ram_wen   = dm_wen;
            ram_addr  = dm_addr;
            ram_wdata = dm_wdata;
        end else if (if_gnt_int) begin
            ram_en    = 1'b1;
            ram_addr  = if_addr;
        end
    end

    // Return-tag FSM: remembers who owns the read data arriving next cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = IDLE;
        if (if_gnt_int) begin
            state_next = RET_IF;
        end else if (dm_read) begin
            state_next = RET_DM;
        end
    end

    always_comb begin
        if_rvalid = 1'b0;
        dm_rvalid = 1'b0;
        case (state_reg)
            RET_IF:  if_rvalid = 1'b1;
            RET_DM:  dm_rvalid = 1'b1;
            default: ;
        endcase
    end

    assign if_rdata = ram_rdata;
    assign dm_rdata = ram_rdata;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_MAX, default 4, meaning the consecutive instruction-fetch losses tolerated before fetch is forced to win (range 1..15).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all flops sample on its rising edge.
REQ-003 The block SHALL have port resetn, input, 1, the reset: asynchronous and active-low.
REQ-004 The block SHALL have port if_req, input, 1, instruction-fetch read request.
REQ-005 The block SHALL have port if_addr, input, 32, instruction-fetch byte address.
REQ-006 The block SHALL have port if_gnt, output, 1, fetch request accepted this cycle.
REQ-007 The block SHALL have port if_rvalid, output, 1, fetch read data valid.
REQ-008 The block SHALL have port if_rdata, output, 32, fetch read data.
REQ-009 The block SHALL have port dm_req, input, 1, data-memory request.
REQ-010 The block SHALL have port dm_wen, input, 4, data byte write enables; 4'b0000 means read.
REQ-011 The block SHALL have port dm_addr, input, 32, data byte address.
REQ-012 The block SHALL have port dm_wdata, input, 32, data store data.
REQ-013 The block SHALL have port dm_gnt, output, 1, data request accepted this cycle.
REQ-014 The block SHALL have port dm_rvalid, output, 1, data load result valid.
REQ-015 The block SHALL have port dm_rdata, output, 32, data load result.
REQ-016 The block SHALL have port ram_en, output, 1, SRAM access enable.
REQ-017 The block SHALL have port ram_wen, output, 4, SRAM byte write enables.
REQ-018 The block SHALL have port ram_addr, output, 32, SRAM byte address.
REQ-019 The block SHALL have port ram_wdata, output, 32, SRAM write data.
REQ-020 The block SHALL have port ram_rdata, input, 32, SRAM read data, valid one cycle after the read access.

Function
REQ-021 The block SHALL share one single-port synchronous SRAM between fetch and data, with at most one grant per cycle.
REQ-022 Grant SHALL be combinational in the request cycle N: ram_en=1 and ram_addr, ram_wen and ram_wdata come from the winner; ram_wen=0 for fetch.
REQ-023 For a read granted in cycle N, the matching rvalid SHALL be 1 in cycle N+1 only, and its rdata SHALL be ram_rdata passed through.
REQ-024 A data write (dm_wen!=0) SHALL complete in its grant cycle and SHALL produce no dm_rvalid.
REQ-025 Back-to-back grants SHALL be allowed, giving a throughput of one access per cycle.
REQ-026 A requester that is not granted SHALL hold its req and request fields stable until granted.
REQ-027 The return-tag FSM SHALL have states IDLE, RET_IF and RET_DM.
REQ-028 The next state SHALL be RET_IF after a fetch grant, RET_DM after a data read grant, and IDLE otherwise (no grant, or a data write).
REQ-029 In state RET_IF, if_rvalid=1; in state RET_DM, dm_rvalid=1; in IDLE, both are 0.
REQ-030 Fixed-priority arbitration: when both request, data SHALL win unless starve_cnt==STARVE_MAX, in which case fetch SHALL win.
REQ-031 starve_cnt SHALL be a 4-bit counter that increments when fetch requests and loses, clears on a fetch grant, holds otherwise, and saturates at STARVE_MAX.
REQ-032 With only one requester, that requester SHALL be granted regardless of starve_cnt.
REQ-033 With no request, ram_en=0, ram_wen=0, and both gnt signals SHALL be 0.

Reset
REQ-034 While resetn=0, the FSM SHALL be IDLE, starve_cnt SHALL be 0, and all gnt, rvalid, ram_en and ram_wen outputs SHALL be 0.
REQ-035 A reset asserted while a read return is pending SHALL discard that return; no rvalid SHALL follow reset release.
REQ-036 On the first cycle after resetn rises, requests SHALL be arbitrated normally.

Configuration
REQ-037 Macro ARB_ROUND_ROBIN_EN SHALL select the arbitration scheme.
REQ-038 When ARB_ROUND_ROBIN_EN is defined, a 1-bit last-winner pointer (reset value: data) SHALL give a tie to the requester not granted last.
REQ-039 When ARB_ROUND_ROBIN_EN is defined, starve_cnt SHALL be absent and STARVE_MAX SHALL be ignored.
REQ-040 When ARB_ROUND_ROBIN_EN is undefined, the block SHALL use the fixed data priority with starvation guard of REQ-030 and REQ-031.

Verification
REQ-041 Scenario: fetch alone, if_addr=0x100, RAM returns 0xDEADBEEF -> if_gnt=1 in cycle N; if_rvalid=1 and if_rdata=0xDEADBEEF in N+1.
REQ-042 Scenario: data write dm_wen=4'b0011, dm_addr=0x204, dm_wdata=0x1234 -> ram_wen=4'b0011 and ram_addr=0x204 in cycle N; no dm_rvalid in N+1.
REQ-043 Scenario: both request continuously, STARVE_MAX=4, fixed mode -> grant sequence D,D,D,D,F repeating; each fetch is granted within 5 cycles.
REQ-044 Scenario: both request continuously, ARB_ROUND_ROBIN_EN defined -> grants alternate F,D,F,D starting with F.
REQ-045 Scenario: alternating data read 0x300 then fetch 0x104 granted back-to-back -> dm_rvalid in N+1, if_rvalid in N+2, each carrying the correct ram_rdata.
REQ-046 Scenario: data read granted, resetn pulsed low in N+1 before the edge -> dm_rvalid=0 throughout, FSM IDLE after release.
